// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory: NOP encoding, ARM condition codes
// and the boot program image that the storage array powers up with.
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int PROG_LEN = 8;

  localparam logic [31:0] PROG_IMAGE [PROG_LEN] = '{
    {COND_AL, 28'h3A0_0014},  // MOV  R0, #20
    {COND_AL, 28'h3A0_1A01},  // MOV  R1, #0x1000
    {COND_AL, 28'h080_2001},  // ADD  R2, R0, R1
    {COND_AL, 28'h352_0000},  // CMP  R2, #0
    {COND_EQ, 28'hA00_0001},  // BEQ  +1
    {COND_NE, 28'h242_2001},  // SUBNE R2, R2, #1
    {COND_AL, 28'h581_2000},  // STR  R2, [R1]
    {COND_AL, 28'hAFF_FFFE}   // B    .
  };

  // Words beyond the program image boot as NOPs.
  function automatic logic [31:0] default_word(input int idx);
    if (idx >= 0 && idx < PROG_LEN) return PROG_IMAGE[idx];
    return NOP_WORD;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one registered read port, one synchronous write port.
// Contents come from the package boot image and are never reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int IDX_W    = 6,
  parameter bit WRITABLE = 1'b1
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] rd_data_q;

  // The read register only moves on rd_en, so a stalled response stays put
  // even while the array is being written.
  if (WRITABLE) begin : g_ram
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t boot_image();
      mem_t img;
      for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(default_word(i));
      return img;
    endfunction

    mem_t mem = boot_image();

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_idx];
    end
  end else begin : g_rom
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_idx, wr_data};

    always_ff @(posedge clk) begin
      if (rd_en) rd_data_q <= DATA_W'(default_word(int'(rd_idx)));
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction fetch front end: valid/ready request, one-deep registered response,
// flush, error detection and delivered-response counter. IMEM_LOAD_PORT_EN adds ld_*.
module instr_mem_fetch
  import imem_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_err,
  input  logic              flush,
`ifdef IMEM_LOAD_PORT_EN
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
`endif
  output logic [15:0]       fetch_cnt
);

  logic              ld_active;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

`ifdef IMEM_LOAD_PORT_EN
  localparam bit WRITABLE = 1'b1;
  assign ld_active = ld_en;
  assign wr_en     = ld_en && !flush && ({1'b0, ld_idx} < (IDX_W+1)'(DEPTH));
  assign wr_idx    = ld_idx;
  assign wr_data   = ld_data;
`else
  localparam bit WRITABLE = 1'b0;
  assign ld_active = 1'b0;
  assign wr_en     = 1'b0;
  assign wr_idx    = '0;
  assign wr_data   = '0;
`endif

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q,   rsp_err_d;
  logic        rsp_mem_q,   rsp_mem_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  logic              addr_ok;
  logic              accept;
  logic              deliver;
  logic [DATA_W-1:0] rd_data;

  assign addr_ok   = (req_addr[1:0] == 2'b00) && ((req_addr >> 2) < ADDR_W'(DEPTH));
  assign req_ready = rst && !flush && !ld_active && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  // A flushed response is discarded, not delivered, even if the consumer was ready.
  assign deliver   = rsp_valid_q && rsp_ready && !flush;

  imem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .WRITABLE(WRITABLE)
  ) u_array (
    .clk    (clk),
    .rd_en  (accept && addr_ok),
    .rd_idx (req_addr[IDX_W+1:2]),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_idx (wr_idx),
    .wr_data(wr_data)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_mem_d   = rsp_mem_q;
    fetch_cnt_d = fetch_cnt_q + 16'(deliver);
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = !addr_ok;
      rsp_mem_d   = addr_ok;
    end else if (deliver) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_mem_q   <= 1'b0;
      fetch_cnt_q <= 16'h0000;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_mem_q   <= rsp_mem_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Error responses and the reset state show NOP instead of stale read data.
  assign rsp_instr = rsp_mem_q ? rd_data : DATA_W'(NOP_WORD);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: directed literal cases plus randomized
// traffic against a transaction-level model. Honours IMEM_LOAD_PORT_EN.
module tb_instr_mem_fetch;
  import imem_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_err;
  logic              flush;
  logic [15:0]       fetch_cnt;
  logic              ld_b;
`ifdef IMEM_LOAD_PORT_EN
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  assign ld_b = ld_en;
`else
  assign ld_b = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_mem_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_err  (rsp_err),
    .flush    (flush),
`ifdef IMEM_LOAD_PORT_EN
    .ld_en    (ld_en),
    .ld_idx   (ld_idx),
    .ld_data  (ld_data),
`endif
    .fetch_cnt(fetch_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, one response slot, delivered count.
  logic [31:0] mdl_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_instr;
  logic        m_err;
  int unsigned delivered;

  wire exp_rdy = rst && !flush && !ld_b && (!m_valid || rsp_ready);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid   <= 1'b0;
      m_instr   <= 32'h0;
      m_err     <= 1'b0;
      delivered <= 0;
    end else begin
      if (m_valid && rsp_ready && !flush) delivered <= delivered + 1;
      if (flush) begin
        m_valid <= 1'b0;
      end else if (req_valid && exp_rdy) begin
        m_valid <= 1'b1;
        if (req_addr % 4 == 0 && req_addr / 4 < DEPTH) begin
          m_instr <= mdl_mem[req_addr / 4];
          m_err   <= 1'b0;
        end else begin
          m_instr <= 32'h0;
          m_err   <= 1'b1;
        end
      end else if (m_valid && rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("fetch_cnt", 32'(fetch_cnt), delivered & 32'hFFFF);
    if (m_valid || !rst) begin
      chk("rsp_instr", rsp_instr, m_instr);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r <= 6) return {22'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (r == 7) return {22'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
    if (r == 8) return 32'(4 * DEPTH) + {20'h0, 10'($urandom_range(0, 255)), 2'b00};
    return $urandom;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = default_word(i);
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
`ifdef IMEM_LOAD_PORT_EN
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
`endif
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_instr", rsp_instr, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_fetch_cnt", 32'(fetch_cnt), 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b1;

    // First fetch of word 0.
    req_valid = 1'b1; req_addr = 32'd0;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("fetch0_valid", 32'(rsp_valid), 32'h1);
    chk("fetch0_instr", rsp_instr, 32'hE3A00014);
    chk("fetch0_err", 32'(rsp_err), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // Back-to-back 0,4,8.
    req_valid = 1'b1; req_addr = 32'd0;
    tick();
    req_addr = 32'd4;
    @(negedge clk);
    chk("b2b_rsp0", rsp_instr, 32'hE3A00014);
    tick();
    req_addr = 32'd8;
    @(negedge clk);
    chk("b2b_rsp1", rsp_instr, 32'hE3A01A01);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rsp2", rsp_instr, 32'hE0802001);
    chk("b2b_valid2", 32'(rsp_valid), 32'h1);
    tick();
    @(negedge clk);
    chk("b2b_cnt", 32'(fetch_cnt), 32'd3);
    chk("b2b_drained", 32'(rsp_valid), 32'h0);

    // Stall with fetch 4 held.
    req_valid = 1'b1; req_addr = 32'd4;
    tick();
    rsp_ready = 1'b0; req_addr = 32'd8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_instr", rsp_instr, 32'hE3A01A01);
      chk("stall_valid", 32'(rsp_valid), 32'h1);
      chk("stall_ready", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("stall_cnt_held", 32'(fetch_cnt), 32'd3);
    tick();
    @(negedge clk);
    chk("stall_no_dup", 32'(rsp_valid), 32'h0);
    chk("stall_cnt", 32'(fetch_cnt), 32'd4);

    // Misaligned and out-of-range fetches.
    req_valid = 1'b1; req_addr = 32'd6;
    tick();
    req_addr = 32'(4 * DEPTH);
    @(negedge clk);
    chk("misalign_instr", rsp_instr, 32'h0);
    chk("misalign_err", 32'(rsp_err), 32'h1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("range_instr", rsp_instr, 32'h0);
    chk("range_err", 32'(rsp_err), 32'h1);
    tick();
    @(negedge clk);
    chk("err_cnt", 32'(fetch_cnt), 32'd6);

    // Flush the cycle after fetching 12.
    req_valid = 1'b1; req_addr = 32'd12;
    tick();
    req_addr = 32'd0; flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'(req_ready), 32'h0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(rsp_valid), 32'h0);
    chk("flush_cnt", 32'(fetch_cnt), 32'd6);

`ifdef IMEM_LOAD_PORT_EN
    ld_en = 1'b1; ld_idx = 6'd3; ld_data = 32'hEAFFFFFF;
    mdl_mem[3] = 32'hEAFFFFFF;
    @(negedge clk);
    chk("load_blocks_req", 32'(req_ready), 32'h0);
    tick();
    ld_en = 1'b0;
    req_valid = 1'b1; req_addr = 32'd12;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("load_fetch12", rsp_instr, 32'hEAFFFFFF);
`endif

    // Reset asserted while a response is pending.
    tick();
    req_valid = 1'b1; req_addr = 32'd0;
    tick();
    req_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_cnt", 32'(fetch_cnt), 32'h0);
    chk("midrst_instr", rsp_instr, 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b1;

    // Randomized traffic, checked every cycle by the model compare.
    for (int n = 0; n < 3000; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = rand_addr();
      flush     = ($urandom_range(0, 19) == 0);
`ifdef IMEM_LOAD_PORT_EN
      ld_en = 1'b0;
      if (!flush && $urandom_range(0, 24) == 0) begin
        ld_en   = 1'b1;
        ld_idx  = 6'($urandom_range(0, DEPTH - 1));
        ld_data = $urandom;
        mdl_mem[ld_idx] = ld_data;
      end
`endif
      rst = ($urandom_range(0, 299) != 0);
      tick();
    end

    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
`ifdef IMEM_LOAD_PORT_EN
    ld_en = 1'b0;
`endif
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 64, words stored; IDX_W = clog2(DEPTH).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1, fetch request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_addr, input, ADDR_W, byte address of fetch.
REQ-009 SHALL have port rsp_valid, output, 1, response held in output register.
REQ-010 SHALL have port rsp_ready, input, 1, consumer takes response.
REQ-011 SHALL have port rsp_instr, output, DATA_W, fetched instruction.
REQ-012 SHALL have port rsp_err, output, 1, fetch was misaligned or out of range.
REQ-013 SHALL have port flush, input, 1, branch-taken discard of in-flight fetch.
REQ-014 SHALL have port fetch_cnt, output, 16, count of responses delivered.
REQ-015 SHALL have ports ld_en (input, 1), ld_idx (input, IDX_W), ld_data (input, DATA_W), word load port; present only per REQ-030.

Function
REQ-016 SHALL use word index = req_addr[IDX_W+1:2]; fetch valid only if req_addr[1:0]==0 and req_addr>>2 < DEPTH.
REQ-017 SHALL drive req_ready = !flush && !ld_en && (!rsp_valid || rsp_ready), combinationally.
REQ-018 SHALL present an accepted fetch on rsp_valid/rsp_instr exactly 1 cycle after acceptance (registered read).
REQ-019 SHALL hold rsp_instr/rsp_err stable while rsp_valid && !rsp_ready; no response lost or duplicated.
REQ-020 SHALL sustain 1 fetch/cycle when rsp_ready stays high (pipelined back-to-back).
REQ-021 SHALL return NOP_WORD with rsp_err=1 for invalid fetch per REQ-016; no array access.
REQ-022 SHALL on flush: clear rsp_valid next cycle, accept no request that cycle, leave fetch_cnt unchanged.
REQ-023 SHALL increment fetch_cnt on each rsp_valid && rsp_ready cycle, including error responses; wraps 0xFFFF->0x0000.
REQ-024 SHALL write ld_data to word ld_idx on ld_en; ld_idx >= DEPTH ignored; the pending output response unaffected.
REQ-025 SHALL give flush priority over ld_en and ld_en priority over requests in the same cycle.

Reset
REQ-026 SHALL on rst low: rsp_valid=0, rsp_instr=NOP_WORD, rsp_err=0, fetch_cnt=0, immediately (asynchronous).
REQ-027 SHALL discard any pending response when reset asserts mid-operation; req_ready=0 during reset.
REQ-028 SHALL NOT reset array contents; array initialised at elaboration from package default program image.
REQ-029 SHALL deassert reset effects on the first rising clk after rst goes high; req_ready valid that cycle.

Configuration
REQ-030 SHALL, with IMEM_LOAD_PORT_EN defined, include ld_* ports and write behaviour of REQ-024.
REQ-031 SHALL, without IMEM_LOAD_PORT_EN, omit ld_* ports, treat ld_en as 0 in REQ-017/REQ-025, array read-only.

Structure
REQ-032 SHALL place NOP_WORD (32'h0), ARM condition-code constants and the default program image in package imem_pkg.
REQ-033 SHALL implement storage as sub-module imem_array: one registered read port, one synchronous write port.
REQ-034 SHALL keep handshake, flush, error and counter logic in instr_mem_fetch only.

Verification
REQ-035 Bench SHALL: reset, fetch addr 0 -> next cycle rsp_instr=32'hE3A00014 (MOV R0,#20), rsp_err=0.
REQ-036 Bench SHALL: fetch 0,4,8 back-to-back with rsp_ready=1 -> 3 responses on consecutive cycles, fetch_cnt=3.
REQ-037 Bench SHALL: rsp_ready=0 for 4 cycles after fetch 4 -> rsp_instr=32'hE3A01A01 held, req_ready=0, no extra response.
REQ-038 Bench SHALL: fetch addr 6 and addr 4*DEPTH -> rsp_instr=32'h0, rsp_err=1 each.
REQ-039 Bench SHALL: flush in cycle after fetch 12 -> rsp_valid=0 next cycle, fetch_cnt unchanged.
REQ-040 Bench SHALL (IMEM_LOAD_PORT_EN): ld_idx=3, ld_data=32'hEAFFFFFF, then fetch 12 -> rsp_instr=32'hEAFFFFFF; rst low mid-fetch -> rsp_valid=0, fetch_cnt=0.
